// File: rtl/md5_pkg.sv
// Shared MD5 padding-controller constants, state encoding and byte-swap helper.
// The S_HEX state exists only when MD5_HEX_OUT_EN is defined.
package md5_pkg;

   localparam int BLK_W   = 512;
   localparam int LEN_POS = 448;

   localparam logic [31:0] IV_A = 32'h67452301;
   localparam logic [31:0] IV_B = 32'hefcdab89;
   localparam logic [31:0] IV_C = 32'h98badcfe;
   localparam logic [31:0] IV_D = 32'h10325476;

`ifdef MD5_HEX_OUT_EN
   typedef enum logic [2:0] {
      S_FILL, S_ISSUE, S_WAIT, S_PAD, S_LENBLK, S_DONE, S_HEX
   } md5_state_e;
`else
   typedef enum logic [2:0] {
      S_FILL, S_ISSUE, S_WAIT, S_PAD, S_LENBLK, S_DONE
   } md5_state_e;
`endif

   // MD5 digest bytes are the little-endian image of each state word
   function automatic logic [31:0] bswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/md5_pad_ctrl_if.sv
// Byte-stream, core and digest signals of md5_pad_ctrl; slave is the controller side.
// Hex output signals are present only with MD5_HEX_OUT_EN.
interface md5_pad_ctrl_if;

   logic                      byte_valid;
   logic [7:0]                byte_data;
   logic                      byte_ready;
   logic                      msg_end;
   logic                      blk_start;
   logic [md5_pkg::BLK_W-1:0] blk_data;
   logic                      core_done;
   logic [31:0]               core_a;
   logic [31:0]               core_b;
   logic [31:0]               core_c;
   logic [31:0]               core_d;
   logic [127:0]              digest;
   logic                      digest_valid;
   logic                      busy;
`ifdef MD5_HEX_OUT_EN
   logic                      hex_valid;
   logic [7:0]                hex_char;

   modport master (
      output byte_valid, byte_data, msg_end, core_done, core_a, core_b, core_c, core_d,
      input  byte_ready, blk_start, blk_data, digest, digest_valid, busy, hex_valid, hex_char
   );
   modport slave (
      input  byte_valid, byte_data, msg_end, core_done, core_a, core_b, core_c, core_d,
      output byte_ready, blk_start, blk_data, digest, digest_valid, busy, hex_valid, hex_char
   );
`else
   modport master (
      output byte_valid, byte_data, msg_end, core_done, core_a, core_b, core_c, core_d,
      input  byte_ready, blk_start, blk_data, digest, digest_valid, busy
   );
   modport slave (
      input  byte_valid, byte_data, msg_end, core_done, core_a, core_b, core_c, core_d,
      output byte_ready, blk_start, blk_data, digest, digest_valid, busy
   );
`endif

endinterface

// File: rtl/md5_hex_ser.sv
// Nibble to lowercase ASCII hex converter; compiled only with MD5_HEX_OUT_EN.
`ifdef MD5_HEX_OUT_EN
module md5_hex_ser (
   input  logic [3:0] nib_i,
   output logic [7:0] char_o
);

   assign char_o = (nib_i < 4'd10) ? (8'h30 + {4'h0, nib_i})
                                   : (8'h57 + {4'h0, nib_i});

endmodule
`endif

// File: rtl/md5_pad_ctrl.sv
// Packs message bytes into 512-bit MD5 blocks, appends 0x80/length padding, launches
// the round core and accumulates A..D. MD5_HEX_OUT_EN adds a serial ASCII hex digest.
//
// state    | meaning
// FILL     | accepting message bytes into slot cnt
// PAD      | writing 0x80, zero tail and (if it fits) the length
// ISSUE    | one-cycle blk_start
// WAIT     | waiting for core_done, then accumulate A..D
// LENBLK   | building the length-only trailing block
// DONE     | digest_valid for one cycle, reinitialise chaining state
// HEX      | streaming 32 hex characters (MD5_HEX_OUT_EN only)
module md5_pad_ctrl #(
   parameter int LEN_W = 32
) (
   input logic           clk,
   input logic           reset_n,
   md5_pad_ctrl_if.slave bus
);
   import md5_pkg::*;

   md5_state_e       state_q;
   logic [6:0]       cnt_q;
   logic [LEN_W-1:0] bitlen_q;
   logic             pad_pend_q;
   logic             final_q;
   logic             end_q;
   logic [BLK_W-1:0] blk_q;
   logic [BLK_W-1:0] pad_blk_d;
   logic [31:0]      a_q, b_q, c_q, d_q;
   logic [31:0]      a_d, b_d, c_d, d_d;
   logic [127:0]     digest_q;
   logic [63:0]      len64;

   assign len64 = 64'(bitlen_q);
   assign a_d   = a_q + bus.core_a;
   assign b_d   = b_q + bus.core_b;
   assign c_d   = c_q + bus.core_c;
   assign d_d   = d_q + bus.core_d;

   always_comb begin
      pad_blk_d = blk_q;
      for (int i = 0; i < 64; i++) begin
         if (7'(i) == cnt_q)
            pad_blk_d[8*i +: 8] = 8'h80;
         else if (7'(i) > cnt_q)
            pad_blk_d[8*i +: 8] = 8'h00;
      end
      if (cnt_q <= 7'd55)
         pad_blk_d[BLK_W-1:LEN_POS] = len64;
   end

`ifdef MD5_HEX_OUT_EN
   logic [4:0] nib_q;
   logic [3:0] hex_nib;

   assign hex_nib = digest_q[7'd127 - {nib_q, 2'b00} -: 4];

   md5_hex_ser u_hex_ser (
      .nib_i  (hex_nib),
      .char_o (bus.hex_char)
   );

   assign bus.hex_valid = (state_q == S_HEX);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_FILL;
         cnt_q      <= '0;
         bitlen_q   <= '0;
         pad_pend_q <= 1'b0;
         final_q    <= 1'b0;
         end_q      <= 1'b0;
         blk_q      <= '0;
         digest_q   <= '0;
         a_q        <= IV_A;
         b_q        <= IV_B;
         c_q        <= IV_C;
         d_q        <= IV_D;
`ifdef MD5_HEX_OUT_EN
         nib_q      <= '0;
`endif
      end else begin
         case (state_q)
            S_FILL: begin
               if (bus.byte_valid) begin
                  blk_q[{cnt_q[5:0], 3'b000} +: 8] <= bus.byte_data;
                  cnt_q    <= cnt_q + 7'd1;
                  bitlen_q <= bitlen_q + LEN_W'(8);
                  if (cnt_q == 7'd63) begin
                     // Full block; an end strobe arriving with the last byte pads the next one
                     final_q <= 1'b0;
                     end_q   <= bus.msg_end;
                     state_q <= S_ISSUE;
                  end else if (bus.msg_end) begin
                     state_q <= S_PAD;
                  end
               end else if (bus.msg_end) begin
                  state_q <= S_PAD;
               end
            end
            S_PAD: begin
               blk_q <= pad_blk_d;
               if (cnt_q <= 7'd55) begin
                  final_q <= 1'b1;
               end else begin
                  final_q    <= 1'b0;
                  pad_pend_q <= 1'b1;
               end
               state_q <= S_ISSUE;
            end
            S_ISSUE: state_q <= S_WAIT;
            S_WAIT: begin
               if (bus.core_done) begin
                  a_q   <= a_d;
                  b_q   <= b_d;
                  c_q   <= c_d;
                  d_q   <= d_d;
                  blk_q <= '0;
                  cnt_q <= '0;
                  if (pad_pend_q) begin
                     state_q <= S_LENBLK;
                  end else if (final_q) begin
                     digest_q <= {bswap32(a_d), bswap32(b_d), bswap32(c_d), bswap32(d_d)};
                     state_q  <= S_DONE;
                  end else if (end_q) begin
                     end_q   <= 1'b0;
                     state_q <= S_PAD;
                  end else begin
                     state_q <= S_FILL;
                  end
               end
            end
            S_LENBLK: begin
               blk_q                  <= '0;
               blk_q[BLK_W-1:LEN_POS] <= len64;
               final_q                <= 1'b1;
               pad_pend_q             <= 1'b0;
               state_q                <= S_ISSUE;
            end
            S_DONE: begin
               a_q      <= IV_A;
               b_q      <= IV_B;
               c_q      <= IV_C;
               d_q      <= IV_D;
               bitlen_q <= '0;
               final_q  <= 1'b0;
`ifdef MD5_HEX_OUT_EN
               nib_q    <= '0;
               state_q  <= S_HEX;
`else
               state_q  <= S_FILL;
`endif
            end
`ifdef MD5_HEX_OUT_EN
            S_HEX: begin
               nib_q <= nib_q + 5'd1;
               if (nib_q == 5'd31)
                  state_q <= S_FILL;
            end
`endif
            default: state_q <= S_FILL;
         endcase
      end
   end

   assign bus.byte_ready   = (state_q == S_FILL);
   assign bus.busy         = (state_q != S_FILL);
   assign bus.blk_start    = (state_q == S_ISSUE);
   assign bus.blk_data     = blk_q;
   assign bus.digest       = digest_q;
   assign bus.digest_valid = (state_q == S_DONE);

endmodule

// File: tb/tb_md5_pad_ctrl.sv
// Scoreboard bench for md5_pad_ctrl with a behavioural MD5 round core.
// Define MD5_HEX_OUT_EN to also check the serial hex output.
module tb_md5_pad_ctrl;

   localparam logic [127:0] IV_ALL    = 128'h67452301_efcdab89_98badcfe_10325476;
   localparam logic [127:0] DIG_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
   localparam logic [127:0] DIG_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   md5_pad_ctrl_if bus_if ();

   md5_pad_ctrl #(.LEN_W(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   logic [31:0] K [0:63] = '{
      32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
      32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
      32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
      32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
      32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
      32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
      32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
      32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
      32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
      32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
      32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
      32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
      32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
      32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
      32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
      32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
   };
   int SR [0:15] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

   // 64 MD5 rounds from chaining value h; returns round results (before feed-forward add)
   function automatic logic [127:0] md5_rounds(input logic [127:0] h, input logic [511:0] blk);
      logic [31:0] a, b, c, d, f;
      int g, s;
      a = h[127:96]; b = h[95:64]; c = h[63:32]; d = h[31:0];
      for (int i = 0; i < 64; i++) begin
         if (i < 16)      begin f = (b & c) | (~b & d); g = i;                end
         else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
         else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
         else             begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
         s = SR[(i / 16) * 4 + (i % 4)];
         f = f + a + K[i] + blk[32*g +: 32];
         a = d; d = c; c = b;
         b = b + ((f << s) | (f >> (32 - s)));
      end
      return {a, b, c, d};
   endfunction

   function automatic logic [127:0] add4(input logic [127:0] x, input logic [127:0] y);
      return {x[127:96] + y[127:96], x[95:64] + y[95:64], x[63:32] + y[63:32], x[31:0] + y[31:0]};
   endfunction

   function automatic logic [31:0] le_word(input logic [31:0] w);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[31-8*k -: 8] = w[8*k +: 8];
      return r;
   endfunction

`ifdef MD5_HEX_OUT_EN
   function automatic logic [7:0] hex_ch(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h61 + 8'(n) - 8'd10);
   endfunction
   logic [7:0] exp_hex_q [$];
   int hex_cnt = 0;
`endif

   logic [511:0] exp_blk_q [$];
   logic [127:0] exp_dig_q [$];
   logic [7:0]   msg [0:127];
   logic [127:0] core_h;
   int rst_epoch = 0;
   int nblk = 0;
   int dig_seen = 0;

   // Behavioural round core with a fixed latency
   initial begin
      logic [511:0] cb;
      logic [127:0] r;
      int ep;
      core_h = IV_ALL;
      bus_if.core_done = 1'b0;
      {bus_if.core_a, bus_if.core_b, bus_if.core_c, bus_if.core_d} = '0;
      forever begin
         @(negedge clk);
         if (bus_if.blk_start) begin
            cb = bus_if.blk_data;
            ep = rst_epoch;
            r  = md5_rounds(core_h, cb);
            repeat (6) @(negedge clk);
            if (ep == rst_epoch) chk("blk_hold", bus_if.blk_data, cb);
            {bus_if.core_a, bus_if.core_b, bus_if.core_c, bus_if.core_d} = r;
            bus_if.core_done = 1'b1;
            @(negedge clk);
            bus_if.core_done = 1'b0;
            if (ep != rst_epoch || bus_if.digest_valid) core_h = IV_ALL;
            else core_h = add4(core_h, r);
         end
      end
   end

   // Output monitor: pops the scoreboard on each DUT output event
   initial begin
      forever begin
         @(negedge clk);
         if (bus_if.blk_start) begin
            nblk++;
            if (exp_blk_q.size() > 0) chk("blk_data", bus_if.blk_data, exp_blk_q.pop_front());
            else chk("blk_extra", 512'(exp_blk_q.size()), 512'd1);
         end
         if (bus_if.digest_valid) begin
            dig_seen++;
            chk("busy_in_done", 512'(bus_if.busy), 512'd1);
            if (exp_dig_q.size() > 0) chk("digest", 512'(bus_if.digest), 512'(exp_dig_q.pop_front()));
            else chk("digest_extra", 512'(exp_dig_q.size()), 512'd1);
         end
`ifdef MD5_HEX_OUT_EN
         if (bus_if.hex_valid) begin
            hex_cnt++;
            chk("busy_in_hex", 512'(bus_if.busy), 512'd1);
            if (exp_hex_q.size() > 0) chk("hex_char", 512'(bus_if.hex_char), 512'(exp_hex_q.pop_front()));
            else chk("hex_extra", 512'(exp_hex_q.size()), 512'd1);
         end
`endif
      end
   end

   task automatic put(input logic v, input logic [7:0] d, input logic e);
      int n;
      n = 0;
      @(negedge clk);
      bus_if.byte_valid = v;
      bus_if.byte_data  = d;
      bus_if.msg_end    = e;
      while (!bus_if.byte_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("byte_ready", 512'(bus_if.byte_ready), 512'd1);
      @(posedge clk);
      #1;
      bus_if.byte_valid = 1'b0;
      bus_if.msg_end    = 1'b0;
   endtask

   task automatic send_msg(input int len, input bit lwe, input bit push_dig,
                           input bit use_const, input logic [127:0] dig_const);
      logic [7:0]   pb [0:191];
      logic [511:0] blk;
      logic [127:0] h, dig;
      logic [63:0]  bl;
      int total;
      total = ((len + 8) / 64 + 1) * 64;
      bl = 64'(len) * 64'd8;
      for (int i = 0; i < total; i++)
         pb[i] = (i < len) ? msg[i] : ((i == len) ? 8'h80 : 8'h00);
      for (int k = 0; k < 8; k++) pb[total-8+k] = bl[8*k +: 8];
      h = IV_ALL;
      for (int b = 0; b < total / 64; b++) begin
         for (int i = 0; i < 64; i++) blk[8*i +: 8] = pb[64*b + i];
         exp_blk_q.push_back(blk);
         h = add4(h, md5_rounds(h, blk));
      end
      dig = use_const ? dig_const
                      : {le_word(h[127:96]), le_word(h[95:64]), le_word(h[63:32]), le_word(h[31:0])};
      if (push_dig) begin
         exp_dig_q.push_back(dig);
`ifdef MD5_HEX_OUT_EN
         for (int i = 0; i < 32; i++) exp_hex_q.push_back(hex_ch(dig[127-4*i -: 4]));
`endif
      end
      for (int i = 0; i < len - 1; i++) put(1'b1, msg[i], 1'b0);
      if (len > 0 && lwe) begin
         put(1'b1, msg[len-1], 1'b1);
      end else begin
         if (len > 0) put(1'b1, msg[len-1], 1'b0);
         put(1'b0, 8'h00, 1'b1);
      end
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while (bus_if.busy && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("idle", 512'(bus_if.busy), 512'd0);
   endtask

   task automatic run_msg(input string tag, input int len, input bit lwe, input bit use_const,
                          input logic [127:0] dc, input int nblocks);
      int n0, d0, w;
      n0 = nblk; d0 = dig_seen; w = 0;
      send_msg(len, lwe, 1'b1, use_const, dc);
      while (dig_seen == d0 && w < 3000) begin
         @(negedge clk);
         w++;
      end
      chk({tag, "_digest_seen"}, 512'(dig_seen - d0), 512'd1);
      chk({tag, "_launches"}, 512'(nblk - n0), 512'(nblocks));
      wait_idle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n0, d0, w;
`ifdef MD5_HEX_OUT_EN
      int h0;
`endif
      bus_if.byte_valid = 1'b0;
      bus_if.byte_data  = 8'h00;
      bus_if.msg_end    = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy",      512'(bus_if.busy), 512'd0);
      chk("rst_blk_start", 512'(bus_if.blk_start), 512'd0);
      chk("rst_blk_data",  bus_if.blk_data, 512'd0);
      chk("rst_digest",    512'(bus_if.digest), 512'd0);
      chk("rst_dvalid",    512'(bus_if.digest_valid), 512'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

`ifdef MD5_HEX_OUT_EN
      h0 = hex_cnt;
`endif
      run_msg("empty", 0, 1'b0, 1'b1, DIG_EMPTY, 1);
`ifdef MD5_HEX_OUT_EN
      chk("hex_count", 512'(hex_cnt - h0), 512'd32);
      chk("hex_left",  512'(exp_hex_q.size()), 512'd0);
`endif

      msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
      run_msg("abc", 3, 1'b0, 1'b1, DIG_ABC, 1);

      for (int i = 0; i < 64; i++) msg[i] = 8'(i * 7 + 3);
      run_msg("len55", 55, 1'b0, 1'b0, '0, 1);
      run_msg("len56", 56, 1'b0, 1'b0, '0, 2);
      for (int i = 0; i < 64; i++) msg[i] = 8'hA5 ^ 8'(i);
      run_msg("len64", 64, 1'b0, 1'b0, '0, 2);
      run_msg("len64_end_with_byte", 64, 1'b1, 1'b0, '0, 2);

      // Abort a message while the core is working
      msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
      n0 = nblk; d0 = dig_seen; w = 0;
      send_msg(3, 1'b0, 1'b0, 1'b0, '0);
      while (nblk == n0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("abort_launch", 512'(nblk - n0), 512'd1);
      @(negedge clk);
      reset_n = 1'b0;
      rst_epoch++;
      @(negedge clk);
      chk("abort_busy",     512'(bus_if.busy), 512'd0);
      chk("abort_blk_data", bus_if.blk_data, 512'd0);
      chk("abort_digest",   512'(bus_if.digest), 512'd0);
      chk("abort_dvalid",   512'(bus_if.digest_valid), 512'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("stale_done_busy",   512'(bus_if.busy), 512'd0);
      chk("stale_done_digest", 512'(dig_seen - d0), 512'd0);
      chk("stale_done_value",  512'(bus_if.digest), 512'd0);

      run_msg("abc_after_reset", 3, 1'b1, 1'b1, DIG_ABC, 1);

      chk("blk_queue_left", 512'(exp_blk_q.size()), 512'd0);
      chk("dig_queue_left", 512'(exp_dig_q.size()), 512'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
